// File: rtl/hex_display_bank.sv
// Registered bank of active-low seven-segment hex digit drivers with load/freeze capture,
// leading-zero blanking, change-detect pulse and optional blinking (HEX_DISPLAY_BANK_BLINK_EN).
module hex_display_bank #(
    parameter int unsigned DIGITS    = 8,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  freeze,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  changed
);

    localparam int unsigned VW = 4 * DIGITS;
    localparam int unsigned HW = 7 * DIGITS;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [VW-1:0]     held;
    logic [HW-1:0]     hex_next;
    logic [DIGITS-1:0] blink_blank;
    logic [DIGITS-1:0] lz_blank;
    logic              capture_c;

    // Active-low {g,f,e,d,c,b,a} code for one nibble.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0: code = 7'b1000000;
            4'h1: code = 7'b1111001;
            4'h2: code = 7'b0100100;
            4'h3: code = 7'b0110000;
            4'h4: code = 7'b0011001;
            4'h5: code = 7'b0010010;
            4'h6: code = 7'b0000010;
            4'h7: code = 7'b1111000;
            4'h8: code = 7'b0000000;
            4'h9: code = 7'b0010000;
            4'hA: code = 7'b0001000;
            4'hB: code = 7'b0000011;
            4'hC: code = 7'b1000110;
            4'hD: code = 7'b0100001;
            4'hE: code = 7'b0000110;
            default: code = 7'b0001110;
        endcase
        return code;
    endfunction

    assign capture_c = load & ~freeze;

    // Capture register, change-detect pulse and registered segment outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            held    <= '0;
            changed <= 1'b0;
            hex     <= {HW{1'b1}};
        end else begin
            if (capture_c) begin
                held <= value;
            end
            changed <= capture_c && (value != held);
            hex     <= hex_next;
        end
    end

`ifdef HEX_DISPLAY_BANK_BLINK_EN
    localparam int unsigned CW = $clog2(BLINK_DIV);

    logic [CW-1:0] bcnt;
    logic          blink_phase;

    // Half-period counter; phase flips on every wrap.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            bcnt        <= '0;
            blink_phase <= 1'b0;
        end else if (bcnt == CW'(BLINK_DIV - 1)) begin
            bcnt        <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            bcnt <= bcnt + CW'(1);
        end
    end

    assign blink_blank = blink_phase ? blink_mask : '0;
`else
    logic unused_blink;

    assign unused_blink = ^blink_mask;
    assign blink_blank  = '0;
`endif

    // Leading-zero scan from the top digit down; digit 0 always shows.
    always_comb begin
        logic zero_above;
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (held[4*i +: 4] == 4'h0) begin
                lz_blank[i] = blank_lz && zero_above && (i != 0);
            end else begin
                zero_above = 1'b0;
            end
        end
    end

    // Blink blanking wins over leading-zero blanking, which wins over the code.
    always_comb begin
        hex_next = {HW{1'b1}};
        for (int i = 0; i < DIGITS; i++) begin
            if (blink_blank[i] || lz_blank[i]) begin
                hex_next[7*i +: 7] = SEG_BLANK;
            end else begin
                hex_next[7*i +: 7] = seg7(held[4*i +: 4]);
            end
        end
    end

endmodule

// File: tb/tb_hex_display_bank.sv
// Bench for hex_display_bank (DIGITS=8, BLINK_DIV=4): vector table, cycle scoreboard and
// hand-written freeze / back-to-back / blink / mid-count reset sequences.
module tb_hex_display_bank;

    localparam int unsigned DIGITS    = 8;
    localparam int unsigned BLINK_DIV = 4;
`ifdef HEX_DISPLAY_BANK_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [31:0] value;
    logic        freeze;
    logic        blank_lz;
    logic [7:0]  blink_mask;
    logic [55:0] hex;
    logic        changed;

    int checks = 0;
    int errors = 0;

    // Model state (post-edge view of the DUT registers).
    logic [31:0] m_held  = '0;
    int          m_bcnt  = 0;
    logic        m_phase = 1'b0;

    logic [55:0] q_hex [$];
    logic        q_chg [$];

    logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct packed {
        logic [31:0]     value;
        logic            blz;
        logic [7:0][6:0] exp;
    } vec_t;

    vec_t vecs [9];

    hex_display_bank #(.DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV)) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .load       (load),
        .value      (value),
        .freeze     (freeze),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .hex        (hex),
        .changed    (changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Predict the next edge, queue it, clock once and compare at the falling edge.
    task automatic cycle();
        logic [55:0] eh;
        logic        ec;
        logic        za;
        logic [3:0]  nib;
        za = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            nib = m_held[4*i +: 4];
            if (BLINK_ON && m_phase && blink_mask[i])
                eh[7*i +: 7] = 7'h7F;
            else if (blank_lz && za && nib == 4'h0 && i != 0)
                eh[7*i +: 7] = 7'h7F;
            else
                eh[7*i +: 7] = seg_lut[nib];
            if (nib != 4'h0) za = 1'b0;
        end
        ec = load && !freeze && (value != m_held);
        q_hex.push_back(eh);
        q_chg.push_back(ec);
        if (load && !freeze) m_held = value;
        if (m_bcnt == BLINK_DIV - 1) begin
            m_bcnt  = 0;
            m_phase = ~m_phase;
        end else begin
            m_bcnt++;
        end
        @(posedge clk);
        @(negedge clk);
        chk("sb_hex", 64'(hex), 64'(q_hex.pop_front()));
        chk("sb_changed", 64'(changed), 64'(q_chg.pop_front()));
    endtask

    task automatic load_val(input logic [31:0] v);
        value = v;
        load  = 1'b1;
        cycle();
        load  = 1'b0;
    endtask

    initial begin
        int blanks;
        vecs[0] = '{32'h000000A5, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12}};
        vecs[1] = '{32'h000000A5, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12}};
        vecs[2] = '{32'h00000000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{32'h00000000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[4] = '{32'hDEADBEEF, 1'b0, {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}};
        vecs[5] = '{32'h01234567, 1'b1, {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}};
        vecs[6] = '{32'h89ABCDEF, 1'b0, {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}};
        vecs[7] = '{32'h00100000, 1'b1, {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[8] = '{32'h80000000, 1'b1, {7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};

        reset = 1'b1; load = 1'b0; value = '0; freeze = 1'b0; blank_lz = 1'b0; blink_mask = '0;
        repeat (2) @(negedge clk);
        chk("reset_hex", 64'(hex), 64'({56{1'b1}}));
        chk("reset_changed", 64'(changed), 64'(0));
        reset = 1'b0;
        cycle();
        chk("first_edge_hex", 64'(hex), 64'({8{7'h40}}));

        // Table of captured values with and without leading-zero blanking.
        for (int i = 0; i < 9; i++) begin
            blank_lz = vecs[i].blz;
            load_val(vecs[i].value);
            cycle();
            chk($sformatf("vec%0d_hex", i), 64'(hex), 64'(vecs[i].exp));
        end

        // Freeze blocks capture; then capture, then identical reload.
        blank_lz = 1'b0;
        load_val(32'h000000A5);
        freeze = 1'b1;
        load_val(32'hDEADBEEF);
        chk("freeze_changed", 64'(changed), 64'(0));
        cycle();
        chk("freeze_hex", 64'(hex), 64'({{6{7'h40}}, 7'h08, 7'h12}));
        freeze = 1'b0;
        load_val(32'hDEADBEEF);
        chk("capture_changed", 64'(changed), 64'(1));
        cycle();
        chk("capture_pulse_end", 64'(changed), 64'(0));
        load_val(32'hDEADBEEF);
        chk("same_value_changed", 64'(changed), 64'(0));

        // Back-to-back loads, including a repeat in the middle.
        value = 32'h1; load = 1'b1; cycle();
        value = 32'h2; cycle();
        value = 32'h2; cycle();
        value = 32'h3; cycle();
        load = 1'b0; cycle(); cycle();

        // All nibble codes through digit 0.
        for (int n = 0; n < 16; n++) begin
            load_val(32'(n));
            cycle();
            chk($sformatf("nib%0d", n), 64'(hex[6:0]), 64'(seg_lut[n]));
        end

        // Blink digit 0: exactly half of any 2*BLINK_DIV window is blank.
        load_val(32'h000000A5);
        blink_mask = 8'h01;
        cycle();
        blanks = 0;
        for (int c = 0; c < 16; c++) begin
            cycle();
            if (hex[6:0] == 7'h7F) blanks++;
            chk("blink_upper_steady", 64'(hex[55:7]), 64'({{6{7'h40}}, 7'h08}));
        end
        chk("blink_count", 64'(blanks), BLINK_ON ? 64'(8) : 64'(0));

        // Reset in the middle of a blink half-period.
        for (int c = 0; c < 16 && !(m_bcnt == 2 && m_phase); c++) cycle();
        chk("reach_mid_blink", 64'(m_bcnt == 2 && m_phase), 64'(1));
        value = 32'h12345678; load = 1'b1;
        reset = 1'b1;
        #1;
        chk("midrst_hex", 64'(hex), 64'({56{1'b1}}));
        chk("midrst_changed", 64'(changed), 64'(0));
        load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_held = '0; m_bcnt = 0; m_phase = 1'b0;
        for (int c = 0; c < 12; c++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
